// File: rtl/counter2_pkg.sv
// Shared definitions for the counter2 code stream: code points, decoder FSM
// states and the legal-successor function.
package counter2_pkg;

  localparam logic [2:0] C0 = 3'b000;
  localparam logic [2:0] C1 = 3'b010;
  localparam logic [2:0] C2 = 3'b011;
  localparam logic [2:0] C3 = 3'b101;
  localparam logic [2:0] C4 = 3'b111;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } c2_state_t;

  // Successor of a legal code; illegal codes fall back to C0 and must not be relied on.
  function automatic logic [2:0] c2_next(input logic [2:0] code);
    logic [2:0] n;
    case (code)
      C0:      n = C1;
      C1:      n = C2;
      C2:      n = C3;
      C3:      n = C4;
      C4:      n = C0;
      default: n = C0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/counter2_code_map.sv
// Combinational map from a counter2 code to {legal, index, successor code}.
module counter2_code_map
  import counter2_pkg::*;
(
  input  logic [2:0] code,
  output logic       legal,
  output logic [2:0] idx,
  output logic [2:0] nxt
);

  always_comb begin
    legal = 1'b1;
    idx   = 3'd0;
    case (code)
      C0:      idx = 3'd0;
      C1:      idx = 3'd1;
      C2:      idx = 3'd2;
      C3:      idx = 3'd3;
      C4:      idx = 3'd4;
      default: legal = 1'b0;
    endcase
    nxt = c2_next(code);
  end

endmodule

// File: rtl/counter2_decoder.sv
// counter2 receive decoder: index decode, lock acquisition and sequence checking.
// Optional saturating error counter enabled by COUNTER2_DECODER_ERRCNT_EN.
//
// state  | meaning
// HUNT   | no reference; waiting for any legal code
// ACQ    | following the sequence, counting consecutive correct transitions
// LOCKED | sequence verified; mismatches are reported as seq_err
module counter2_decoder
  import counter2_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             code_vld,
  output logic [2:0]       idx,
  output logic             idx_vld,
  output logic             illegal,
  output logic             seq_err,
  output logic             wrap,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);

  c2_state_t      state, state_d;
  logic [2:0]     exp_code, exp_d;
  logic [GW-1:0]  good, good_d, good_inc;
  logic [BW-1:0]  bad, bad_d, bad_inc;
  logic [2:0]     idx_d;
  logic           idx_vld_d, illegal_d, seq_err_d, wrap_d;

  logic [2:0]     code;
  logic           map_legal;
  logic [2:0]     map_idx, map_nxt;

  assign code     = {a, b, c};
  assign good_inc = good + GW'(1);
  assign bad_inc  = bad + BW'(1);

  counter2_code_map u_map (
    .code  (code),
    .legal (map_legal),
    .idx   (map_idx),
    .nxt   (map_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HUNT;
      exp_code <= C0;
      good     <= '0;
      bad      <= '0;
      idx      <= 3'd0;
      idx_vld  <= 1'b0;
      illegal  <= 1'b0;
      seq_err  <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_d;
      exp_code <= exp_d;
      good     <= good_d;
      bad      <= bad_d;
      idx      <= idx_d;
      idx_vld  <= idx_vld_d;
      illegal  <= illegal_d;
      seq_err  <= seq_err_d;
      wrap     <= wrap_d;
    end
  end

  always_comb begin
    state_d   = state;
    exp_d     = exp_code;
    good_d    = good;
    bad_d     = bad;
    idx_d     = idx;
    idx_vld_d = 1'b0;
    illegal_d = 1'b0;
    seq_err_d = 1'b0;
    wrap_d    = 1'b0;
    if (code_vld) begin
      idx_vld_d = map_legal;
      illegal_d = !map_legal;
      if (map_legal) idx_d = map_idx;
      case (state)
        HUNT: begin
          if (map_legal) begin
            state_d = ACQ;
            exp_d   = map_nxt;
            good_d  = '0;
          end
        end
        ACQ: begin
          if (!map_legal) begin
            state_d = HUNT;
          end else if (code == exp_code) begin
            good_d = good_inc;
            exp_d  = map_nxt;
            if (good_inc == GW'(LOCK_CNT)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            exp_d  = map_nxt;
            good_d = '0;
          end
        end
        LOCKED: begin
          if (map_legal && code == exp_code) begin
            bad_d  = '0;
            exp_d  = map_nxt;
            wrap_d = (code == C0);
          end else begin
            seq_err_d = 1'b1;
            bad_d     = bad_inc;
            if (bad_inc == BW'(LOSS_CNT)) state_d = HUNT;
            // Illegal samples carry no position, so advance the expectation blindly.
            else if (map_legal) exp_d = map_nxt;
            else exp_d = c2_next(exp_code);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

`ifdef COUNTER2_DECODER_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt <= '0;
    else if (seq_err_d && err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_counter2_decoder.sv
// Self-checking bench for counter2_decoder: directed vector table, error
// saturation sequence and randomized stimulus against a position-based model.
module tb_counter2_decoder;

  localparam int LOCK = 3;
  localparam int LOSS = 2;
  localparam int EW   = 2;

  logic          clk = 1'b0;
  logic          rst_n, a, b, c, code_vld;
  logic [2:0]    idx;
  logic          idx_vld, illegal, seq_err, wrap, locked;
  logic [EW-1:0] err_cnt;

  counter2_decoder #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .code_vld(code_vld),
    .idx(idx), .idx_vld(idx_vld), .illegal(illegal), .seq_err(seq_err),
    .wrap(wrap), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: the sequence as an ordered list; progress tracked by position mod 5.
  logic [2:0] seq [5] = '{3'b000, 3'b010, 3'b011, 3'b101, 3'b111};
  int m_mode, m_epos, m_good, m_bad, m_idx, m_err;
  bit m_vld, m_ill, m_se, m_wrap;

  function automatic int pos_of(input logic [2:0] code);
    for (int i = 0; i < 5; i++) if (seq[i] == code) return i;
    return -1;
  endfunction

  function automatic int sat_err(input int raw);
`ifdef COUNTER2_DECODER_ERRCNT_EN
    return (raw > (1 << EW) - 1) ? (1 << EW) - 1 : raw;
`else
    return 0 * raw;
`endif
  endfunction

  task automatic model_step(input bit rst, input logic [2:0] code, input bit vld);
    int p;
    m_vld = 0; m_ill = 0; m_se = 0; m_wrap = 0;
    if (rst) begin
      m_mode = 0; m_epos = 0; m_good = 0; m_bad = 0; m_idx = 0; m_err = 0;
      return;
    end
    if (!vld) return;
    p = pos_of(code);
    if (p >= 0) begin m_vld = 1; m_idx = p; end
    else m_ill = 1;
    case (m_mode)
      0: if (p >= 0) begin m_mode = 1; m_epos = (p + 1) % 5; m_good = 0; end
      1: begin
        if (p < 0) m_mode = 0;
        else if (p == m_epos) begin
          m_good++;
          m_epos = (p + 1) % 5;
          if (m_good == LOCK) begin m_mode = 2; m_bad = 0; end
        end else begin
          m_epos = (p + 1) % 5; m_good = 0;
        end
      end
      default: begin
        if (p >= 0 && p == m_epos) begin
          m_bad = 0; m_wrap = (p == 0); m_epos = (p + 1) % 5;
        end else begin
          m_se = 1; m_err++; m_bad++;
          if (m_bad == LOSS) m_mode = 0;
          else m_epos = (p >= 0) ? (p + 1) % 5 : (m_epos + 1) % 5;
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic drive(input bit rst, input logic [2:0] code, input bit vld);
    rst_n = !rst;
    {a, b, c} = code;
    code_vld = vld;
    @(posedge clk);
    #1;
    model_step(rst, code, vld);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".idx"}, idx, m_idx);
    chk({tag, ".idx_vld"}, idx_vld, m_vld);
    chk({tag, ".illegal"}, illegal, m_ill);
    chk({tag, ".seq_err"}, seq_err, m_se);
    chk({tag, ".wrap"}, wrap, m_wrap);
    chk({tag, ".locked"}, locked, m_mode == 2);
    chk({tag, ".err_cnt"}, err_cnt, sat_err(m_err));
  endtask

  typedef struct {
    bit rst; logic [2:0] code; bit vld;
    int idx; bit iv; bit il; bit se; bit wr; bit lk; int err;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit rst, logic [2:0] code, bit vld, int ix,
                              bit iv, bit il, bit se, bit wr, bit lk, int err);
    vec_t v;
    v.rst = rst; v.code = code; v.vld = vld; v.idx = ix; v.iv = iv;
    v.il = il; v.se = se; v.wr = wr; v.lk = lk; v.err = err;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; {a, b, c} = 3'b000; code_vld = 1'b0;
    m_mode = 0; m_epos = 0; m_good = 0; m_bad = 0; m_idx = 0; m_err = 0;
    m_vld = 0; m_ill = 0; m_se = 0; m_wrap = 0;
    repeat (2) @(posedge clk);
    #1;

    // rst code vld | idx iv il se wr lk err
    tbl.push_back(mk(1, 3'b111, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 1, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b011, 1, 2, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b101, 1, 3, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 3'b111, 1, 4, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 3'b100, 1, 0, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 3'b101, 1, 3, 1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 3'b000, 1, 0, 1, 0, 0, 0, 0, 2));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 3'b010, 1, 1, 1, 0, 0, 0, 0, 2));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 3'b110, 0, 1, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 3'b011, 1, 2, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 3'b101, 1, 3, 1, 0, 0, 0, 1, 2));
    tbl.push_back(mk(1, 3'b111, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 1, 1, 1, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].code, tbl[i].vld);
      chk($sformatf("vec%0d.idx", i), idx, tbl[i].idx);
      chk($sformatf("vec%0d.idx_vld", i), idx_vld, tbl[i].iv);
      chk($sformatf("vec%0d.illegal", i), illegal, tbl[i].il);
      chk($sformatf("vec%0d.seq_err", i), seq_err, tbl[i].se);
      chk($sformatf("vec%0d.wrap", i), wrap, tbl[i].wr);
      chk($sformatf("vec%0d.locked", i), locked, tbl[i].lk);
      chk($sformatf("vec%0d.err_cnt", i), err_cnt, sat_err(tbl[i].err));
    end

    // Six locked errors with re-lock in between; the 2-bit counter must stick at 3.
    for (int r = 0; r < 3; r++) begin
      drive(0, 3'b100, 1); chk_model("sat");
      drive(0, 3'b100, 1); chk_model("sat");
      for (int k = 0; k < 4; k++) begin drive(0, seq[k], 1); chk_model("sat"); end
      chk("sat.relock", locked, 1);
      drive(0, 3'b100, 1); chk_model("sat");
      drive(0, 3'b100, 1); chk_model("sat");
    end
`ifdef COUNTER2_DECODER_ERRCNT_EN
    chk("sat.err_final", err_cnt, 3);
`else
    chk("sat.err_final", err_cnt, 0);
`endif
    chk("sat.locked_final", locked, 0);

    for (int n = 0; n < 3000; n++) begin
      logic [2:0] code;
      bit vld, rst;
      if ($urandom_range(0, 9) < 7) code = seq[m_epos];
      else code = 3'($urandom_range(0, 7));
      vld = ($urandom_range(0, 9) < 8);
      rst = ($urandom_range(0, 199) == 0);
      drive(rst, code, vld);
      chk_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
